// File: rtl/if_pkg.sv
`default_nettype none
// ============================================================================
// Module      : if_pkg
// Description : Shared defaults and types for the instruction-fetch stage.
// Revision    : 1.0 - initial release
// ============================================================================
package if_pkg;

    localparam int          c_ADDR_W   = 32;
    localparam int          c_INSTR_W  = 32;
    localparam int          c_PC_STEP  = 4;
    localparam logic [31:0] c_RESET_PC = 32'h0000_0000;

    // Field order matches the packed {pc, instr} words held in the fetch FIFO
    typedef struct packed {
        logic [c_ADDR_W-1:0]  pc;
        logic [c_INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo
// Description : Circular-buffer FIFO with occupancy count and synchronous flush.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head_data,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;

    logic w_empty;
    logic w_full;
    logic w_do_pop;
    logic w_do_push;

    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == c_CNT_W'(DEPTH));
    assign w_do_pop  = pop && !w_empty;
    // A pop in the same cycle frees the slot a full-FIFO push needs
    assign w_do_push = push && (!w_full || w_do_pop);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= push_data;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_do_pop && !w_do_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    assign head_data = r_mem[r_rd_ptr];
    assign count     = r_count;

endmodule
`default_nettype wire

// File: rtl/if_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : if_fetch_unit
// Description : Decoupled fetch stage: credit-limited requests to an in-order
//               variable-latency imem, response FIFO, redirect flush/drop.
// Revision    : 1.0 - initial release
// ============================================================================
module if_fetch_unit
    import if_pkg::*;
#(
    parameter int                ADDR_W   = c_ADDR_W,
    parameter int                INSTR_W  = c_INSTR_W,
    parameter int                DEPTH    = 4,
    parameter int                PC_STEP  = c_PC_STEP,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(c_RESET_PC)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               branch_taken,
    input  logic [ADDR_W-1:0]  branch_address,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_gnt,
    input  logic               imem_rvalid,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] instruction,
    output logic [ADDR_W-1:0]  pc_value
);

    localparam int                c_CNT_W = $clog2(DEPTH+1);
    localparam int                c_ENT_W = ADDR_W + INSTR_W;
    localparam logic [ADDR_W-1:0] c_STEP  = ADDR_W'(PC_STEP);

    logic [ADDR_W-1:0]  r_fetch_pc;
    logic [c_CNT_W-1:0] r_inflight;
    logic [c_CNT_W-1:0] r_drop;

    logic [c_CNT_W-1:0] w_fifo_count;
    logic [c_CNT_W-1:0] w_shadow_count;
    logic [c_ENT_W-1:0] w_fifo_head;
    logic [c_ENT_W-1:0] w_fifo_push_data;
    logic [ADDR_W-1:0]  w_shadow_head;
    logic [c_CNT_W:0]   w_credit_used;
    logic               w_req_fire;
    logic               w_resp_keep;
    logic               w_pop;

    // Outstanding plus buffered work may never exceed the FIFO, so every
    // response that comes back is guaranteed a slot.
    assign w_credit_used = {1'b0, w_fifo_count} + {1'b0, r_inflight};
    assign imem_req      = (w_credit_used < (c_CNT_W+1)'(DEPTH)) && !branch_taken;
    assign imem_addr     = r_fetch_pc;
    assign w_req_fire    = imem_req && imem_gnt;

    assign w_resp_keep = imem_rvalid && (r_drop == '0) && !branch_taken
                         && (w_shadow_count != '0);

    assign out_valid = (w_fifo_count != '0) && !branch_taken;
    assign w_pop     = out_valid && out_ready;

    assign w_fifo_push_data = {w_shadow_head + c_STEP, imem_rdata};
    assign instruction      = w_fifo_head[INSTR_W-1:0];
    assign pc_value         = w_fifo_head[c_ENT_W-1:INSTR_W];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_fetch_pc <= RESET_PC;
        end else if (branch_taken) begin
            r_fetch_pc <= branch_address;
        end else if (w_req_fire) begin
            r_fetch_pc <= r_fetch_pc + c_STEP;
        end
    end

    // Every response retires one in-flight request, stale or not
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_inflight <= '0;
        end else begin
            r_inflight <= r_inflight + c_CNT_W'(w_req_fire) - c_CNT_W'(imem_rvalid);
        end
    end

    // On redirect, everything still outstanding becomes stale except a
    // response that lands in the redirect cycle itself, which is dropped now.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_drop <= '0;
        end else if (branch_taken) begin
            r_drop <= r_drop + r_inflight - c_CNT_W'(imem_rvalid);
        end else if (imem_rvalid && (r_drop != '0)) begin
            r_drop <= r_drop - 1'b1;
        end
    end

    sync_fifo #(
        .WIDTH (c_ENT_W),
        .DEPTH (DEPTH)
    ) u_instr_fifo (
        .clock     (clock),
        .reset     (reset),
        .flush     (branch_taken),
        .push      (w_resp_keep),
        .push_data (w_fifo_push_data),
        .pop       (w_pop),
        .head_data (w_fifo_head),
        .count     (w_fifo_count)
    );

    sync_fifo #(
        .WIDTH (ADDR_W),
        .DEPTH (DEPTH)
    ) u_addr_shadow (
        .clock     (clock),
        .reset     (reset),
        .flush     (branch_taken),
        .push      (w_req_fire),
        .push_data (imem_addr),
        .pop       (w_resp_keep),
        .head_data (w_shadow_head),
        .count     (w_shadow_count)
    );

endmodule
`default_nettype wire

// File: tb/tb_if_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_if_fetch_unit
// Description : Directed self-checking bench for if_fetch_unit with an
//               in-order fixed-latency instruction-memory model.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_if_fetch_unit;

    logic        clk            = 1'b0;
    logic        rst_n          = 1'b0;
    logic        branch_taken   = 1'b0;
    logic [31:0] branch_address = 32'h0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt       = 1'b1;
    logic        imem_rvalid    = 1'b0;
    logic [31:0] imem_rdata     = 32'h0;
    logic        out_valid;
    logic        out_ready      = 1'b0;
    logic [31:0] instruction;
    logic [31:0] pc_value;

    always #5 clk = ~clk;

    if_fetch_unit #(
        .ADDR_W   (32),
        .INSTR_W  (32),
        .DEPTH    (4),
        .PC_STEP  (4),
        .RESET_PC (32'h0)
    ) dut (
        .clock          (clk),
        .reset          (rst_n),
        .branch_taken   (branch_taken),
        .branch_address (branch_address),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .instruction    (instruction),
        .pc_value       (pc_value)
    );

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    typedef struct {
        bit          rst;
        bit          ready;
        bit          e_req;
        logic [31:0] e_addr;
        bit          e_valid;
        logic [31:0] e_instr;
        logic [31:0] e_pc;
    } vec_t;

    pend_t       pend_q[$];
    vec_t        vt[18];
    int          cyc = 1;
    int          lat = 1;
    int          obs_cyc;
    int          n_cmp = 0;
    int          n_err = 0;
    logic        obs_req, obs_valid, obs_rvalid;
    logic [31:0] obs_addr, obs_instr, obs_pc;
    logic        found;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock cycle, entered and left at a falling edge.
    task automatic tick();
        int s;
        if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = pend_q[0].addr ^ 32'hA5A5_0000;
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = 32'h0;
        end
        #1;
        obs_cyc    = cyc;
        obs_req    = imem_req;
        obs_addr   = imem_addr;
        obs_valid  = out_valid;
        obs_instr  = instruction;
        obs_pc     = pc_value;
        obs_rvalid = imem_rvalid;
        if (imem_req && imem_gnt) pend_q.push_back('{addr: imem_addr, due: cyc + lat});
        if (imem_rvalid) void'(pend_q.pop_front());
        @(posedge clk);
        @(negedge clk);
        s = int'(dut.r_drop) + int'(dut.r_inflight);
        chk("drop_inflight_bound", 32'(s <= 4), 32'd1);
        cyc++;
    endtask

    task automatic do_reset();
        rst_n        = 1'b0;
        branch_taken = 1'b0;
        out_ready    = 1'b0;
        imem_rvalid  = 1'b0;
        imem_rdata   = 32'h0;
        pend_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cyc   = 1;
    endtask

    task automatic wait_valid(output logic got);
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            tick();
            if (obs_valid) got = 1'b1;
        end
        if (!got) chk("wait_valid_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Stream with always-ready decode, then stall/resume with DEPTH credits
        vt[0]  = '{1'b1, 1'b1, 1'b1, 32'h00, 1'b0, 32'h0,         32'h00};
        vt[1]  = '{1'b0, 1'b1, 1'b1, 32'h04, 1'b0, 32'h0,         32'h00};
        vt[2]  = '{1'b0, 1'b1, 1'b1, 32'h08, 1'b1, 32'hA5A5_0000, 32'h04};
        vt[3]  = '{1'b0, 1'b1, 1'b1, 32'h0C, 1'b1, 32'hA5A5_0004, 32'h08};
        vt[4]  = '{1'b0, 1'b1, 1'b1, 32'h10, 1'b1, 32'hA5A5_0008, 32'h0C};
        vt[5]  = '{1'b0, 1'b1, 1'b1, 32'h14, 1'b1, 32'hA5A5_000C, 32'h10};
        vt[6]  = '{1'b0, 1'b1, 1'b1, 32'h18, 1'b1, 32'hA5A5_0010, 32'h14};
        vt[7]  = '{1'b0, 1'b1, 1'b1, 32'h1C, 1'b1, 32'hA5A5_0014, 32'h18};
        vt[8]  = '{1'b1, 1'b0, 1'b1, 32'h00, 1'b0, 32'h0,         32'h00};
        vt[9]  = '{1'b0, 1'b0, 1'b1, 32'h04, 1'b0, 32'h0,         32'h00};
        vt[10] = '{1'b0, 1'b0, 1'b1, 32'h08, 1'b1, 32'hA5A5_0000, 32'h04};
        vt[11] = '{1'b0, 1'b0, 1'b1, 32'h0C, 1'b1, 32'hA5A5_0000, 32'h04};
        vt[12] = '{1'b0, 1'b0, 1'b0, 32'h10, 1'b1, 32'hA5A5_0000, 32'h04};
        vt[13] = '{1'b0, 1'b0, 1'b0, 32'h10, 1'b1, 32'hA5A5_0000, 32'h04};
        vt[14] = '{1'b0, 1'b1, 1'b0, 32'h10, 1'b1, 32'hA5A5_0000, 32'h04};
        vt[15] = '{1'b0, 1'b1, 1'b1, 32'h10, 1'b1, 32'hA5A5_0004, 32'h08};
        vt[16] = '{1'b0, 1'b1, 1'b1, 32'h14, 1'b1, 32'hA5A5_0008, 32'h0C};
        vt[17] = '{1'b0, 1'b1, 1'b1, 32'h18, 1'b1, 32'hA5A5_000C, 32'h10};

        // Reset state
        @(negedge clk);
        #1;
        chk("rst_out_valid",   32'(out_valid), 32'd0);
        chk("rst_imem_req",    32'(imem_req),  32'd1);
        chk("rst_imem_addr",   imem_addr,      32'h0);
        chk("rst_instruction", instruction,    32'h0);
        chk("rst_pc_value",    pc_value,       32'h0);
        @(negedge clk);

        lat = 1;
        for (int i = 0; i < 18; i++) begin
            if (vt[i].rst) do_reset();
            out_ready = vt[i].ready;
            tick();
            chk($sformatf("vec%0d_req", i),   32'(obs_req),   32'(vt[i].e_req));
            chk($sformatf("vec%0d_addr", i),  obs_addr,       vt[i].e_addr);
            chk($sformatf("vec%0d_valid", i), 32'(obs_valid), 32'(vt[i].e_valid));
            chk($sformatf("vec%0d_instr", i), obs_instr,      vt[i].e_instr);
            chk($sformatf("vec%0d_pc", i),    obs_pc,         vt[i].e_pc);
        end

        // Redirect with three requests outstanding at L = 3
        do_reset();
        lat = 3;
        out_ready = 1'b1;
        tick(); tick(); tick();
        branch_taken = 1'b1;
        branch_address = 32'h100;
        tick();
        branch_taken = 1'b0;
        chk("t3_req_in_branch", 32'(obs_req), 32'd0);
        chk("t3_drop_count",    32'(dut.r_drop), 32'd2);
        tick();
        chk("t3_redirect_req",  32'(obs_req), 32'd1);
        chk("t3_redirect_addr", obs_addr, 32'h100);
        wait_valid(found);
        if (found) begin
            chk("t3_first_cycle", 32'(obs_cyc), 32'd9);
            chk("t3_first_pc",    obs_pc,       32'h104);
            chk("t3_first_instr", obs_instr,    32'hA5A5_0100);
        end

        // Redirect coinciding with a response and a ready decode, L = 2
        do_reset();
        lat = 2;
        out_ready = 1'b1;
        tick(); tick(); tick(); tick();
        branch_taken = 1'b1;
        branch_address = 32'h200;
        tick();
        branch_taken = 1'b0;
        chk("t4_rvalid_in_branch", 32'(obs_rvalid), 32'd1);
        chk("t4_valid_in_branch",  32'(obs_valid),  32'd0);
        chk("t4_drop_count",       32'(dut.r_drop), 32'd1);
        wait_valid(found);
        if (found) begin
            chk("t4_first_pc",    obs_pc,    32'h204);
            chk("t4_first_instr", obs_instr, 32'hA5A5_0200);
        end

        // Address wrap at the top of the space
        do_reset();
        lat = 1;
        out_ready = 1'b1;
        tick();
        branch_taken = 1'b1;
        branch_address = 32'hFFFF_FFFC;
        tick();
        branch_taken = 1'b0;
        tick();
        chk("t5_addr_top",  obs_addr, 32'hFFFF_FFFC);
        tick();
        chk("t5_addr_wrap", obs_addr, 32'h0);
        wait_valid(found);
        if (found) begin
            chk("t5_wrap_pc",    obs_pc,    32'h0);
            chk("t5_wrap_instr", obs_instr, 32'h5A5A_FFFC);
            tick();
            chk("t5_next_valid", 32'(obs_valid), 32'd1);
            chk("t5_next_pc",    obs_pc,    32'h4);
            chk("t5_next_instr", obs_instr, 32'hA5A5_0000);
        end

        // Asynchronous reset while buffered and in flight
        do_reset();
        lat = 3;
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        chk("t6_pre_valid",    32'(obs_valid), 32'd1);
        chk("t6_pre_inflight", 32'(dut.r_inflight != 0), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_async_valid", 32'(out_valid), 32'd0);
        chk("t6_async_addr",  imem_addr,      32'h0);
        chk("t6_async_req",   32'(imem_req),  32'd1);
        chk("t6_async_instr", instruction,    32'h0);
        chk("t6_async_pc",    pc_value,       32'h0);
        pend_q.delete();
        imem_rvalid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cyc = 1;
        lat = 1;
        out_ready = 1'b1;
        tick();
        chk("t6_restart_addr",  obs_addr, 32'h0);
        chk("t6_restart_valid1", 32'(obs_valid), 32'd0);
        tick();
        chk("t6_restart_valid2", 32'(obs_valid), 32'd0);
        tick();
        chk("t6_restart_valid3", 32'(obs_valid), 32'd1);
        chk("t6_restart_pc",     obs_pc,    32'h4);
        chk("t6_restart_instr",  obs_instr, 32'hA5A5_0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/if_fetch_unit.md
# if_fetch_unit

Parametrised, decoupled instruction-fetch stage. Holds the fetch PC, issues requests to a variable-latency, in-order instruction memory, and buffers returned instructions in a small FIFO. The FIFO feeds decode through a valid/ready handshake. Branch redirects flush the FIFO and discard responses still in flight; this replaces the fixed single-cycle PC/ROM fetch path.

## Interface
Parameters:
- ADDR_W, 32, PC and memory address width
- INSTR_W, 32, instruction width
- DEPTH, 4, FIFO entries and maximum in-flight-plus-buffered instructions; power of two, ≥2
- PC_STEP, 4, PC increment per fetched instruction
- RESET_PC, 0, fetch PC after reset

Ports:
- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low reset
- branch_taken  in  1  redirect request, one-cycle pulse
- branch_address  in  ADDR_W  redirect target
- imem_req  out  1  fetch request valid
- imem_addr  out  ADDR_W  fetch address (= fetch_pc)
- imem_gnt  in  1  request accepted when imem_req && imem_gnt
- imem_rvalid  in  1  response valid; responses return in request order
- imem_rdata  in  INSTR_W  response instruction
- out_valid  out  1  instruction available to decode
- out_ready  in  1  decode accepts; pop when out_valid && out_ready
- instruction  out  INSTR_W  FIFO head instruction
- pc_value  out  ADDR_W  FIFO head fetch address + PC_STEP

## Operation
- State:
  - fetch_pc (ADDR_W)
  - FIFO of {pc+PC_STEP, instr}, count 0..DEPTH
  - inflight counter: accepted requests without a response yet
  - drop counter: stale in-flight responses still to be discarded
  - Counters are $clog2(DEPTH+1) bits.
- Credit rule: imem_req = (count + inflight < DEPTH) && !branch_taken. Every accepted response is guaranteed a FIFO slot.
- Accepted request:
  - fetch_pc += PC_STEP, modulo 2^ADDR_W
  - inflight += 1
  - The request address is pushed onto an address shadow queue, depth DEPTH, so each response can be paired with its PC.
- Response while drop > 0: discarded; drop -= 1, inflight -= 1.
- Response while drop == 0: pushed to the FIFO as {addr+PC_STEP, imem_rdata}; inflight -= 1.
- Pop: FIFO head advances. out_valid = (count != 0) && !branch_taken.
- Redirect (branch_taken = 1):
  - fetch_pc <= branch_address.
  - FIFO and shadow queue are cleared.
  - No pop and no request that cycle.
  - A response arriving that cycle is discarded.
  - drop <= drop + inflight − (rvalid ? 1 : 0).
- Simultaneous push and pop: count unchanged.
- Reset values: FIFO empty and all counters 0, so out_valid = 0 and imem_req = 1. fetch_pc = RESET_PC, imem_addr = RESET_PC, instruction = 0, pc_value = 0.
- Reset mid-operation: all state returns to reset values immediately. The memory side is expected to be reset by the same signal, so no drop bookkeeping carries over reset.

## Timing
- Request accepted at cycle t, response at t+L (L ≥ 1): out_valid rises at t+L+1. There is no rvalid-to-output bypass.
- Back-to-back fetch with L = 1 and out_ready = 1: one instruction per cycle in steady state, provided DEPTH ≥ L+1.
- Redirect at cycle t: the first request to branch_address is issued at t+1. The first redirected instruction is visible no earlier than t+2+L.
- When count + inflight = DEPTH, imem_req = 0 until a pop frees a slot; the request may issue in the cycle after the pop.
- Drop counter saturation is impossible: drop + inflight ≤ DEPTH always holds. The bench asserts this.

## Structure
- Package if_pkg: default ADDR_W, INSTR_W, PC_STEP, RESET_PC; typedef fetch_entry_t {pc, instr}.
- Sub-module sync_fifo #(WIDTH, DEPTH):
  - circular buffer with count, push/pop/flush, asynchronous active-low reset
  - instantiated twice: the instruction FIFO, width ADDR_W+INSTR_W, and the address shadow queue, width ADDR_W.
- Top level holds fetch_pc, the inflight/drop counters and the handshake logic.

## Test plan
- Reset, then imem L = 1 returning rdata = addr ^ 32'hA5A5_0000, out_ready = 1:
  - first out_valid at cycle 3
  - instruction/pc_value pairs 32'hA5A5_0000/4, 32'hA5A5_0004/8, …, one per cycle.
- out_ready = 0 with L = 1:
  - exactly DEPTH = 4 requests (addresses 0, 4, 8, 12) are accepted, then imem_req = 0
  - raising out_ready resumes requests at 16 the cycle after the first pop.
- L = 3 with 3 requests in flight, branch_taken with branch_address = 32'h100:
  - all 3 old responses are dropped
  - the next accepted imem_addr is 32'h100
  - first output has pc_value = 32'h104.
- branch_taken in the same cycle as imem_rvalid and out_ready: no pop, response discarded, out_valid = 0 that cycle, drop = inflight − 1.
- fetch_pc = 32'hFFFF_FFFC: the next request wraps to address 0; pc_value for that entry = 0.
- Assert reset low while the FIFO is full and requests are in flight:
  - out_valid = 0, imem_addr = RESET_PC immediately
  - after release, fetch restarts at RESET_PC with no stale output.
